// File: rtl/joystick_pkg.sv
// Shared encodings for the joystick move FSM: direction codes, FSM states and
// the bit positions of the per-direction zone vector driven onto dir_level.
package joystick_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam int ZB_UP    = 0;
    localparam int ZB_DOWN  = 1;
    localparam int ZB_LEFT  = 2;
    localparam int ZB_RIGHT = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_FIRE,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/joy_axis_zone.sv
// Per-axis hysteresis comparator: tracks whether one ADC axis sits in its low
// or high zone, and exposes the next-state zones plus |code-CENTER| for arbitration.
module joy_axis_zone #(
    parameter int ADC_W  = 12,
    parameter int CENTER = 2048,
    parameter int DEAD   = 600,
    parameter int HYST   = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [ADC_W-1:0] code,
    output logic             hi,
    output logic             lo,
    output logic             hi_next,
    output logic             lo_next,
    output logic [ADC_W-1:0] dev_abs
);

    localparam logic signed [ADC_W:0] CENTER_S = (ADC_W+1)'(CENTER);
    localparam logic signed [ADC_W:0] DEAD_S   = (ADC_W+1)'(DEAD);
    localparam logic signed [ADC_W:0] NDEAD_S  = -DEAD_S;
    localparam logic [ADC_W-1:0]      REL_U    = ADC_W'(DEAD - HYST);

    logic signed [ADC_W:0] dev;
    logic hi_q, hi_d;
    logic lo_q, lo_d;

    // One extra bit keeps code-CENTER exact for every unsigned code.
    function automatic logic [ADC_W-1:0] abs_dev(input logic signed [ADC_W:0] d);
        logic signed [ADC_W:0] mag;
        mag = d[ADC_W] ? -d : d;
        return mag[ADC_W-1:0];
    endfunction

    always_comb begin
        dev     = $signed({1'b0, code}) - CENTER_S;
        dev_abs = abs_dev(dev);
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (sample_valid) begin
            if (dev > DEAD_S) begin
                hi_d = 1'b1;
                lo_d = 1'b0;
            end else if (dev < NDEAD_S) begin
                hi_d = 1'b0;
                lo_d = 1'b1;
            end else if (dev_abs <= REL_U) begin
                hi_d = 1'b0;
                lo_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= 1'b0;
            lo_q <= 1'b0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi      = hi_q;
    assign lo      = lo_q;
    assign hi_next = hi_d;
    assign lo_next = lo_d;

endmodule

// File: rtl/joystick_move_fsm.sv
// Joystick-to-move-command FSM with per-axis hysteresis zones and debounce.
// Define JOYSTICK_AUTOREPEAT_EN to re-fire a held direction every REPEAT_CYC cycles.
module joystick_move_fsm
    import joystick_pkg::*;
#(
    parameter int ADC_W      = 12,
    parameter int CENTER     = 2048,
    parameter int DEAD       = 600,
    parameter int HYST       = 100,
    parameter int HOLD_SMP   = 3,
    parameter int REPEAT_CYC = 5_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ADC_W-1:0] adc_x_value,
    input  logic [ADC_W-1:0] adc_y_value,
    input  logic             sample_valid,
    output logic             move_valid,
    output logic [1:0]       move_dir,
    input  logic             move_ready,
    output logic [3:0]       dir_level
);

    if (HYST >= DEAD) begin : g_bad_hyst
        $error("joystick_move_fsm: HYST must be smaller than DEAD");
    end
    if (CENTER + DEAD > (1 << ADC_W) - 1) begin : g_bad_top
        $error("joystick_move_fsm: CENTER+DEAD exceeds the ADC range");
    end
    if (CENTER < DEAD) begin : g_bad_bottom
        $error("joystick_move_fsm: CENTER must be at least DEAD");
    end
    if (HOLD_SMP == 0) begin : g_bad_hold
        $error("joystick_move_fsm: HOLD_SMP must be non-zero");
    end
    if (REPEAT_CYC < 1) begin : g_bad_repeat
        $error("joystick_move_fsm: REPEAT_CYC must be positive");
    end

    localparam int               CNT_W  = $clog2(HOLD_SMP + 2);
    localparam logic [CNT_W-1:0] HOLD_N = CNT_W'(HOLD_SMP);

    logic             x_hi, x_lo, x_hi_n, x_lo_n;
    logic             y_hi, y_lo, y_hi_n, y_lo_n;
    logic [ADC_W-1:0] x_dev, y_dev;

    joy_axis_zone #(
        .ADC_W (ADC_W),
        .CENTER(CENTER),
        .DEAD  (DEAD),
        .HYST  (HYST)
    ) u_zone_x (
        .clk         (clk),
        .reset       (reset),
        .sample_valid(sample_valid),
        .code        (adc_x_value),
        .hi          (x_hi),
        .lo          (x_lo),
        .hi_next     (x_hi_n),
        .lo_next     (x_lo_n),
        .dev_abs     (x_dev)
    );

    joy_axis_zone #(
        .ADC_W (ADC_W),
        .CENTER(CENTER),
        .DEAD  (DEAD),
        .HYST  (HYST)
    ) u_zone_y (
        .clk         (clk),
        .reset       (reset),
        .sample_valid(sample_valid),
        .code        (adc_y_value),
        .hi          (y_hi),
        .lo          (y_lo),
        .hi_next     (y_hi_n),
        .lo_next     (y_lo_n),
        .dev_abs     (y_dev)
    );

    logic       x_act, y_act, cand_vld;
    logic [1:0] cand;

    // Candidate uses this sample's zones so the Nth qualifying sample fires next cycle.
    always_comb begin
        x_act    = x_hi_n | x_lo_n;
        y_act    = y_hi_n | y_lo_n;
        cand_vld = x_act | y_act;
        cand     = DIR_UP;
        if (x_act && (!y_act || x_dev >= y_dev)) begin
            cand = x_hi_n ? DIR_RIGHT : DIR_LEFT;
        end else if (y_act) begin
            cand = y_hi_n ? DIR_UP : DIR_DOWN;
        end
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dir_q, dir_d;
    logic [1:0]       mdir_q, mdir_d;
    logic             load_en;
    logic [1:0]       load_dir;
    logic [CNT_W-1:0] load_cnt;

`ifdef JOYSTICK_AUTOREPEAT_EN
    localparam int               TMR_W    = $clog2(REPEAT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REPEAT_CYC - 1);
    logic [TMR_W-1:0] timer_q, timer_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        mdir_d   = mdir_q;
        load_en  = 1'b0;
        load_dir = dir_q;
        load_cnt = cnt_q;
`ifdef JOYSTICK_AUTOREPEAT_EN
        timer_d  = timer_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (sample_valid && cand_vld) begin
                    load_en  = 1'b1;
                    load_dir = cand;
                    load_cnt = CNT_W'(1);
                end
            end
            ST_ARM: begin
                if (sample_valid) begin
                    if (!cand_vld) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cand == dir_q) begin
                        load_en  = 1'b1;
                        load_dir = dir_q;
                        load_cnt = cnt_q + CNT_W'(1);
                    end else begin
                        load_en  = 1'b1;
                        load_dir = cand;
                        load_cnt = CNT_W'(1);
                    end
                end
            end
            // Command is frozen until the consumer takes it; samples only move the zones.
            ST_FIRE: begin
                if (move_ready) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
`ifdef JOYSTICK_AUTOREPEAT_EN
                    timer_d = '0;
`endif
                end
            end
            ST_HOLD: begin
                if (sample_valid && !cand_vld) begin
                    state_d = ST_IDLE;
                end else if (sample_valid && cand != dir_q) begin
                    load_en  = 1'b1;
                    load_dir = cand;
                    load_cnt = CNT_W'(1);
                end
`ifdef JOYSTICK_AUTOREPEAT_EN
                else if (timer_q == TMR_LAST) begin
                    state_d = ST_FIRE;
                    mdir_d  = dir_q;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
`else
                else begin
                    state_d = ST_HOLD;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_en) begin
            dir_d = load_dir;
            if (load_cnt >= HOLD_N) begin
                state_d = ST_FIRE;
                mdir_d  = load_dir;
                cnt_d   = '0;
            end else begin
                state_d = ST_ARM;
                cnt_d   = load_cnt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_UP;
            mdir_q  <= DIR_UP;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            mdir_q  <= mdir_d;
        end
    end

`ifdef JOYSTICK_AUTOREPEAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    always_comb begin
        dir_level           = '0;
        dir_level[ZB_UP]    = y_hi;
        dir_level[ZB_DOWN]  = y_lo;
        dir_level[ZB_LEFT]  = x_lo;
        dir_level[ZB_RIGHT] = x_hi;
    end

    assign move_valid = (state_q == ST_FIRE);
    assign move_dir   = mdir_q;

endmodule

// File: doc/joystick_move_fsm.md
JOYSTICK_MOVE_FSM -- requirements
Module: joystick_move_fsm

Interface
REQ-001 Parameter ADC_W, 12, ADC sample width in bits.
REQ-002 Parameter CENTER, 2048, neutral ADC code.
REQ-003 Parameter DEAD, 600, deadzone half-width; deflection beyond CENTER±DEAD activates a zone.
REQ-004 Parameter HYST, 100, release hysteresis; an active zone clears only inside CENTER±(DEAD-HYST).
REQ-005 Parameter HOLD_SMP, 3, consecutive qualifying samples required before a move fires.
REQ-006 Parameter REPEAT_CYC, 5_000_000, clock cycles between auto-repeat moves.
REQ-007 clk  input  1  system clock; all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 adc_x_value  input  ADC_W  X-axis ADC code, unsigned.
REQ-010 adc_y_value  input  ADC_W  Y-axis ADC code, unsigned.
REQ-011 sample_valid  input  1  one-cycle strobe: both ADC values are new and coherent.
REQ-012 move_valid  output  1  move command pending.
REQ-013 move_dir  output  2  command direction: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT.
REQ-014 move_ready  input  1  consumer accepts the command.
REQ-015 dir_level  output  4  live zone state {RIGHT,LEFT,DOWN,UP}, for LEDs.

Function
REQ-016 The block SHALL evaluate zones only on cycles with sample_valid=1; other cycles hold all zone state.
REQ-017 Zone activation per axis: code > CENTER+DEAD -> high side (X RIGHT, Y UP); code < CENTER-DEAD -> low side (X LEFT, Y DOWN).
REQ-018 Active-zone release: code within [CENTER-DEAD+HYST, CENTER+DEAD-HYST]; between the activation and release thresholds, the previous zone state SHALL be held.
REQ-019 Deviation SHALL be computed as signed ADC_W+1 bits, |code-CENTER|, with no overflow.
REQ-020 With both axes active, the axis of larger deviation SHALL be the candidate direction; on a tie, X wins.
REQ-021 FSM states: IDLE, ARM, FIRE, HOLD.
REQ-022 IDLE: a candidate on a valid sample -> ARM, with the sample counter at 1.
REQ-023 ARM: same candidate -> counter+1, reaching HOLD_SMP -> FIRE; different candidate -> restart ARM at 1 with the new direction; neutral -> IDLE.
REQ-024 FIRE: move_valid=1 and move_dir latched; move_dir SHALL stay stable until move_valid&&move_ready; on that cycle -> HOLD, with the repeat timer cleared.
REQ-025 A pending command SHALL NOT be withdrawn or changed if the stick is released or moved during FIRE.
REQ-026 HOLD: neutral -> IDLE; different candidate -> ARM at 1; same candidate -> remain in HOLD (auto-repeat behaviour is set in REQ-031).
REQ-027 Latency: move_valid SHALL rise on the cycle after the HOLD_SMP-th qualifying sample_valid.
REQ-028 dir_level SHALL reflect the per-axis zone registers; multiple bits may be set.

Reset
REQ-029 Reset SHALL immediately force: state IDLE, counters 0, zones clear, move_valid=0, move_dir=0, dir_level=0, including mid-FIRE or mid-HOLD.

Configuration
REQ-030 Macro JOYSTICK_AUTOREPEAT_EN SHALL select auto-repeat.
REQ-031 Defined: in HOLD with the same candidate, the repeat timer counts cycles; at REPEAT_CYC-1 -> FIRE with the same direction. Undefined: the timer is absent; exactly one move per deflection, and the stick must return to neutral (or change direction) to fire again.

Structure
REQ-032 Package joystick_pkg SHALL hold the direction encodings (DIR_UP..DIR_RIGHT), the FSM state type, and the zone-vector bit indices.
REQ-033 Sub-module joy_axis_zone (the per-axis hysteresis comparator, with low/high outputs) SHALL be instantiated once per axis.
REQ-034 Elaboration SHALL fail if HYST >= DEAD, CENTER+DEAD > 2^ADC_W-1, CENTER < DEAD, or HOLD_SMP = 0.

Verification (ADC_W=12, CENTER=2048, DEAD=600, HYST=100, HOLD_SMP=3, REPEAT_CYC=20)
REQ-035 Three samples with x=3000, y=2048, move_ready=1 -> one move_valid pulse, move_dir=3, on the cycle after sample 3; dir_level=4'b1000.
REQ-036 x=3000, then x=2600, then x=2500 -> RIGHT is held at 2600 (hysteresis band) and clears at 2500 (release).
REQ-037 x=100 (dev 1948) and y=3900 (dev 1852) for 3 samples -> move_dir=2; with x=3900 and y=3900 -> move_dir=3 (tie, X wins).
REQ-038 Fire DOWN with move_ready=0 for 10 cycles, stick released meanwhile -> move_valid held, move_dir=1 stable; accepted on the ready cycle; then IDLE.
REQ-039 Hold UP with the macro defined -> repeated moves 20 cycles after each acceptance; without the macro -> exactly one move.
REQ-040 Assert reset during FIRE -> move_valid=0 asynchronously; after release, no command fires until 3 new qualifying samples.
